// File: rtl/tt_scan_ctrl_pkg.sv
// Shared types and helpers for the exhaustive truth-table scan controller
// and the classification harness that reuses the self-dual checker.
package tt_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StCheck,
      StDone
   } scan_state_e;

   localparam int unsigned N_IN_DEF = 7;
   localparam int unsigned TT_W     = 2 ** N_IN_DEF;
   localparam int unsigned CNT_W    = N_IN_DEF + 1;

   // Largest table the fold helper accepts; narrower tables are zero-extended.
   localparam int unsigned MAX_N_IN = 10;
   localparam int unsigned MAX_TT_W = 2 ** MAX_N_IN;

   // f is self-dual iff every complementary pair (i, w-1-i) holds opposite values.
   function automatic logic self_dual_fold(input logic [MAX_TT_W-1:0] tt,
                                           input int unsigned         w);
      logic                sd;
      logic [MAX_N_IN-1:0] lo;
      logic [MAX_N_IN-1:0] hi;
      sd = (w != 0);
      lo = '0;
      hi = '0;
      for (int unsigned i = 0; i < MAX_TT_W; i++) begin
         if (i < w) begin
            lo = MAX_N_IN'(i);
            hi = MAX_N_IN'(w - 1 - i);
            sd = sd & (tt[lo] ^ tt[hi]);
         end
      end
      return sd;
   endfunction

endpackage

// File: rtl/tt_self_dual_chk.sv
// Combinational self-duality check over a complete truth table.
module tt_self_dual_chk #(
   parameter int unsigned W = 128
) (
   input  logic [W-1:0] tt,
   output logic         self_dual
);
   import tt_scan_ctrl_pkg::*;

   logic [MAX_TT_W-1:0] tt_ext;

   always_comb begin
      tt_ext = '0;
      tt_ext[W-1:0] = tt;
   end

   assign self_dual = self_dual_fold(tt_ext, W);

endmodule

// File: rtl/tt_scan_ctrl.sv
// Drives an N-input combinational network through every input vector, captures its
// truth table and reports onset count and self-duality over a valid/ready result port.
module tt_scan_ctrl
   import tt_scan_ctrl_pkg::*;
#(
   parameter int unsigned N_IN   = N_IN_DEF,
   parameter int unsigned SETTLE = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic [N_IN-1:0]        x_out,
   input  logic                   f_in,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [(1<<N_IN)-1:0]   res_tt,
   output logic [N_IN:0]          res_ones,
   output logic                   res_self_dual
);

   localparam int unsigned TtW = 1 << N_IN;
   localparam int unsigned CntW = N_IN + 1;
   localparam logic [3:0] SettleInit = 4'(SETTLE);
   localparam logic [N_IN-1:0] IdxLast = {N_IN{1'b1}};

   scan_state_e     state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [3:0]      settle_q, settle_d;
   logic [TtW-1:0]  acc_q, acc_d;
   logic [CntW-1:0] ones_q, ones_d;
   logic [TtW-1:0]  res_tt_q, res_tt_d;
   logic [CntW-1:0] res_ones_q, res_ones_d;
   logic            res_sd_q, res_sd_d;
   logic            res_valid_q, res_valid_d;
   logic            acc_self_dual;

   tt_self_dual_chk #(
      .W (TtW)
   ) u_sd_chk (
      .tt        (acc_q),
      .self_dual (acc_self_dual)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      settle_d    = settle_q;
      acc_d       = acc_q;
      ones_d      = ones_q;
      res_tt_d    = res_tt_q;
      res_ones_d  = res_ones_q;
      res_sd_d    = res_sd_q;
      res_valid_d = res_valid_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StScan;
               idx_d    = '0;
               settle_d = SettleInit;
               acc_d    = '0;
               ones_d   = '0;
            end
         end
         StScan: begin
            if (abort) begin
               state_d = StIdle;
               idx_d   = '0;
            end else if (settle_q == 4'd0) begin
               // Last cycle of this vector: sample, then step x_out on the same edge.
               acc_d[idx_q] = f_in;
               ones_d       = ones_q + CntW'(f_in);
               idx_d        = idx_q + N_IN'(1);
               settle_d     = SettleInit;
               if (idx_q == IdxLast) begin
                  state_d = StCheck;
               end
            end else begin
               settle_d = settle_q - 4'd1;
            end
         end
         StCheck: begin
            if (abort) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               res_tt_d    = acc_q;
               res_ones_d  = ones_q;
               res_sd_d    = acc_self_dual;
               res_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            idx_d       = '0;
            res_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         settle_q    <= '0;
         acc_q       <= '0;
         ones_q      <= '0;
         res_tt_q    <= '0;
         res_ones_q  <= '0;
         res_sd_q    <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         settle_q    <= settle_d;
         acc_q       <= acc_d;
         ones_q      <= ones_d;
         res_tt_q    <= res_tt_d;
         res_ones_q  <= res_ones_d;
         res_sd_q    <= res_sd_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign busy          = (state_q != StIdle);
   assign x_out         = idx_q;
   assign res_valid     = res_valid_q;
   assign res_tt        = res_tt_q;
   assign res_ones      = res_ones_q;
   assign res_self_dual = res_sd_q;

endmodule

// File: doc/tt_scan_ctrl.md
Name: tt_scan_ctrl

Overview:
- Sequencer that exhaustively drives a combinational N-input single-output logic network (default 7 inputs, e.g. a majority-gate network) through all 2^N input vectors.
- Captures the output into a full truth table and computes classification attributes: onset count and self-duality.
- Sits between the classification harness (start/result handshake) and the network under evaluation (x_out/f_in).

Parameters:
N_IN, 7, number of network inputs; truth table width is 2^N_IN.
SETTLE, 0, extra wait cycles after each x_out change before f_in is sampled (0 to 15).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a scan; accepted only in IDLE
abort  input  1  terminate the scan in progress; return to IDLE without a result
busy  output  1  high in every state except IDLE
x_out  output  N_IN  input vector driven to the network; registered
f_in  input  1  network output for the current x_out; combinational path, no register in the network
res_valid  output  1  result available
res_ready  input  1  result consumer accepts
res_tt  output  2^N_IN  truth table; bit i = f(x_out=i)
res_ones  output  N_IN+1  number of 1s in res_tt, range 0 to 2^N_IN
res_self_dual  output  1  1 iff f(~x) = ~f(x) for all x

Behaviour:
- Reset (async, rst_n low) puts the block in IDLE, and it stays there while rst_n is low. All outputs are 0: busy, x_out, res_valid, res_tt, res_ones, res_self_dual. The internal index, settle counter and accumulators are cleared.
- Reset asserted in mid-scan discards all partial state.
- States: IDLE, SCAN, CHECK, DONE.
- IDLE:
  - start=1 moves to SCAN next cycle.
  - On entry to SCAN: x_out=0, idx=0, settle counter=SETTLE, truth-table accumulator and onset counter cleared.
  - res_* keep the last result values, with res_valid=0.
- SCAN:
  - Each vector is held for SETTLE+1 cycles.
  - f_in is sampled on the last of those cycles into tt_acc[idx], and the onset counter increments when f_in=1.
  - idx then increments and x_out follows on the same edge.
  - After sampling idx=2^N_IN-1, go to CHECK. x_out wraps to 0 and holds there.
  - SCAN duration is exactly 2^N_IN*(SETTLE+1) cycles; for defaults, 128 cycles.
- CHECK:
  - One cycle.
  - self_dual = AND over i of (tt_acc[i] XOR tt_acc[2^N_IN-1-i]). An all-zero or all-one table gives 0.
  - On the exit edge: res_tt, res_ones and res_self_dual are loaded, res_valid is set, and the FSM goes to DONE.
- DONE:
  - res_valid=1 and the result stays stable until res_valid and res_ready are both high on the same cycle.
  - That handshake clears res_valid and returns to IDLE. start is not accepted in the same cycle.
  - res_ready while res_valid=0 is ignored.
- abort:
  - Effective in SCAN and CHECK only. The next state is IDLE, x_out=0, res_valid stays 0 and the res_* values are unchanged.
  - Ignored in IDLE and DONE; an issued result cannot be withdrawn.
  - abort takes priority over the SCAN to CHECK transition.
- start while busy=1 is ignored, not queued.
- res_ones counter width N_IN+1 holds 2^N_IN without overflow.
- Latency from the start accept edge to res_valid: 2^N_IN*(SETTLE+1)+1 cycles, which is 129 for the defaults.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/SCAN/CHECK/DONE);
  - localparams TT_W = 2**N_IN and CNT_W = N_IN+1;
  - a helper function for the self-dual fold.
- One natural sub-module: tt_self_dual_chk. It is combinational, takes TT_W bits and returns 1 bit, and is reused by the classification harness.
- The FSM, index/settle counters and accumulators stay in tt_scan_ctrl.

Test Plan:
- Network = 7-input majority network (MAJ3 tree over x0..x6), start pulse, res_ready=1 → res_valid rises exactly 129 cycles after accept; res_ones=64; res_self_dual=1; res_tt matches a bench-computed model.
- f_in = x_out[0], SETTLE=2 → res_tt is alternating 0101 from bit 0 (0xAAAA…A); res_ones=64; res_self_dual=1; latency 385 cycles; each x_out value is held 3 cycles.
- f_in tied 0, then f_in = x_out[0]&x_out[1] → first run gives res_tt=0, res_ones=0, res_self_dual=0; second run gives res_ones=32, res_self_dual=0.
- abort at idx=50 → next cycle is IDLE with busy=0, x_out=0, res_valid=0 and res_* equal to the previous run; a following start produces a correct full result.
- Backpressure: res_ready=0 for 20 cycles in DONE → res_valid and res_* stay stable, a start pulse during this time is ignored, and the state returns to IDLE one cycle after res_ready=1.
- rst_n low at idx=70, released after 3 cycles → all outputs 0, no spurious res_valid; the next scan is correct.
